// File: rtl/pattern_bank.sv
// pattern_bank: double-buffered pattern store. A shadow bank is loaded either
// serially (one bit per cycle while ssel is high) or one entry at a time
// through the field port. commit copies the whole shadow bank into the active
// bank, which drives the outputs.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ssel, sin     serial shift enable and data in
//   sout          serial data out (MSB of the last shadow entry)
//   fieldp        entry pointer for field write and field read
//   field_in      field write data
//   field_write   write field_in into shadow[fieldp]
//   field_byte    active[fieldp], or 0 when fieldp is out of range
//   commit        copy the shadow bank into the active bank
//   pattern       active bank, flattened (entry i at [i*WIDTH +: WIDTH])
//   busy          a serial frame is in progress
//   load_done     one-cycle pulse after the last bit of a frame
//   dirty         shadow has been modified since the last commit
module pattern_bank #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 32,
   parameter int unsigned PTR_W = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ssel,
   input  logic                   sin,
   output logic                   sout,
   input  logic [PTR_W-1:0]       fieldp,
   input  logic [WIDTH-1:0]       field_in,
   input  logic                   field_write,
   output logic [WIDTH-1:0]       field_byte,
   input  logic                   commit,
   output logic [WIDTH*DEPTH-1:0] pattern,
   output logic                   busy,
   output logic                   load_done,
   output logic                   dirty
);

   localparam int unsigned TOTAL = WIDTH * DEPTH;
   localparam int unsigned CNT_W = $clog2(TOTAL);

   typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_nx;
   logic             load_done_nx;
   logic             dirty_nx;
   logic             shift_en;
   logic             wr_en;
   logic             cm_en;
   logic             in_range;

   logic [WIDTH-1:0] shadow [DEPTH];
   logic [WIDTH-1:0] active [DEPTH];

   // Wide compare so the check stays correct when 2**PTR_W == DEPTH
   assign in_range = (32'(fieldp) < DEPTH);

   // Next-state, counter and write/commit qualification
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      load_done_nx = 1'b0;
      shift_en     = ssel;
      wr_en        = 1'b0;
      cm_en        = 1'b0;
      case (state)
         IDLE, READY: begin
            if (ssel) begin
               state_nx = LOAD;
               count_nx = CNT_W'(1);
            end else begin
               wr_en = field_write && in_range;
               cm_en = commit;
               if (commit) begin
                  state_nx = IDLE;
               end
            end
         end
         LOAD: begin
            if (ssel) begin
               // count holds shifts already taken; this one is number count+1
               if (count == CNT_W'(TOTAL - 1)) begin
                  state_nx     = READY;
                  count_nx     = '0;
                  load_done_nx = 1'b1;
               end else begin
                  count_nx = count + CNT_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
            count_nx = '0;
         end
      endcase

      // A modification in the same cycle as a commit keeps the bank dirty
      dirty_nx = dirty;
      if (shift_en || wr_en) begin
         dirty_nx = 1'b1;
      end else if (cm_en) begin
         dirty_nx = 1'b0;
      end
   end

   // Control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= '0;
         load_done <= 1'b0;
         busy      <= 1'b0;
         dirty     <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         load_done <= load_done_nx;
         busy      <= (state_nx == LOAD);
         dirty     <= dirty_nx;
      end
   end

   // Shadow and active banks; active samples the pre-edge shadow on commit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         if (shift_en) begin
            shadow[0] <= {shadow[0][WIDTH-2:0], sin};
            for (int i = 1; i < int'(DEPTH); i++) begin
               shadow[i] <= {shadow[i][WIDTH-2:0], shadow[i-1][WIDTH-1]};
            end
         end else if (wr_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               if (fieldp == PTR_W'(i)) begin
                  shadow[i] <= field_in;
               end
            end
         end
         if (cm_en) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
               active[i] <= shadow[i];
            end
         end
      end
   end

   assign sout = shadow[DEPTH-1][WIDTH-1];

   // Field read mux over the active bank
   always_comb begin
      field_byte = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (fieldp == PTR_W'(i)) begin
            field_byte = active[i];
         end
      end
   end

   // Flatten the active bank
   always_comb begin
      pattern = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         pattern[i*WIDTH +: WIDTH] = active[i];
      end
   end

endmodule
